// File: rtl/prng_pkg.sv
// Shared constants and FSM state type for the pseudorandom word generator.
package prng_pkg;

  localparam logic [31:0] DEFAULT_TAPS  = 32'h8020_0003;
  localparam int unsigned ZERO_SEED_SUB = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/prng_word_gen_if.sv
// Request/response bundle between the GA controller and the word generator.
interface prng_word_gen_if #(
  parameter int WIDTH    = 8,
  parameter int LFSR_LEN = 32
);
  logic                start;
  logic                reseed;
  logic [LFSR_LEN-1:0] seed;
  logic [WIDTH-1:0]    value;
  logic                busy;
  logic                done;

  modport master (output start, reseed, seed, input value, busy, done);
  modport slave  (input start, reseed, seed, output value, busy, done);
endinterface

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR that advances STEP positions per enabled clock.
module lfsr_galois
  import prng_pkg::*;
#(
  parameter int                  LFSR_LEN = 32,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEFAULT_TAPS,
  parameter int                  STEP     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] load_value,
  input  logic                advance,
  output logic [LFSR_LEN-1:0] state,
  output logic [STEP-1:0]     out_bits
);

  logic [LFSR_LEN-1:0] state_q;
  logic [LFSR_LEN-1:0] state_d;
  logic [LFSR_LEN-1:0] chain [STEP+1];

  assign chain[0] = state_q;

  // Earliest emitted bit of the group lands in out_bits[STEP-1].
  for (genvar i = 0; i < STEP; i++) begin : g_unroll
    assign chain[i+1]          = (chain[i] >> 1) ^ (chain[i][0] ? TAPS : '0);
    assign out_bits[STEP-1-i]  = chain[i][0];
  end

  assign state_d = chain[STEP];
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LFSR_LEN'(ZERO_SEED_SUB);
    end else if (load) begin
      state_q <= load_value;
    end else if (advance) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/prng_word_gen.sv
// Builds WIDTH-bit pseudorandom words from a Galois LFSR, reloading the seed only when needed.
module prng_word_gen
  import prng_pkg::*;
#(
  parameter int                  WIDTH    = 8,
  parameter int                  LFSR_LEN = 32,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEFAULT_TAPS,
  parameter int                  STEP     = 1
) (
  input logic             clk,
  input logic             reset,
  prng_word_gen_if.slave  bus
);

  localparam int N_CYC = WIDTH / STEP;
  localparam int CNT_W = $clog2(N_CYC + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    value_q;
  logic                busy_q;
  logic                done_q;
  logic                seed_valid_q;
  logic [LFSR_LEN-1:0] last_seed_q;
  logic [LFSR_LEN-1:0] seed_q;

  logic [LFSR_LEN-1:0] eff_seed;
  logic [LFSR_LEN-1:0] lfsr_state;
  logic [STEP-1:0]     group;
  logic                need_load;

  // The all-zero state would lock the LFSR up, so it is never loaded.
  assign eff_seed  = (seed_q == '0) ? LFSR_LEN'(ZERO_SEED_SUB) : seed_q;
  assign need_load = bus.reseed || !seed_valid_q || (bus.seed != last_seed_q);

  lfsr_galois #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .STEP     (STEP)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (state_q == LOAD),
    .load_value (eff_seed),
    .advance    (state_q == RUN),
    .state      (lfsr_state),
    .out_bits   (group)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      value_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seed_valid_q <= 1'b0;
      last_seed_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            seed_q  <= bus.seed;
            cnt_q   <= '0;
            value_q <= '0;
            busy_q  <= 1'b1;
            state_q <= need_load ? LOAD : RUN;
          end
        end
        LOAD: begin
          last_seed_q  <= seed_q;
          seed_valid_q <= 1'b1;
          value_q      <= '0;
          state_q      <= RUN;
        end
        RUN: begin
          value_q <= (value_q << STEP) | WIDTH'(group);
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_CYC - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.value = value_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_prng_word_gen.sv
// Directed bench for prng_word_gen: STEP=1 and STEP=2 instances, scoreboard of expected words.
module tb_prng_word_gen;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prng_word_gen_if #(.WIDTH(8), .LFSR_LEN(32)) if1 ();
  prng_word_gen_if #(.WIDTH(8), .LFSR_LEN(32)) if2 ();

  prng_word_gen #(.WIDTH(8), .LFSR_LEN(32), .TAPS(TAPS), .STEP(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  prng_word_gen #(.WIDTH(8), .LFSR_LEN(32), .TAPS(TAPS), .STEP(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  typedef struct {
    logic [7:0] val;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  logic [31:0] m_lfsr  [2];
  bit          m_valid [2];
  logic [31:0] m_last  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i]  = 32'h1;
      m_valid[i] = 1'b0;
      m_last[i]  = 32'h0;
    end
  endtask

  // Reference: Galois right shift, first bit shifted out ends up in the word's MSB.
  task automatic model_word(input int sel, input logic [31:0] s, input bit rs,
                            output logic [7:0] v, output int lat);
    bit ld;
    ld = rs || !m_valid[sel] || (s != m_last[sel]);
    if (ld) begin
      m_lfsr[sel]  = (s == 32'h0) ? 32'h1 : s;
      m_last[sel]  = s;
      m_valid[sel] = 1'b1;
    end
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], m_lfsr[sel][0]};
      m_lfsr[sel] = (m_lfsr[sel] >> 1) ^ (m_lfsr[sel][0] ? TAPS : 32'h0);
    end
    lat = ((sel != 0) ? 4 : 8) + (ld ? 2 : 1);
  endtask

  function automatic logic get_done(input int sel);
    return (sel != 0) ? if2.done : if1.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? if2.busy : if1.busy;
  endfunction

  function automatic logic [7:0] get_value(input int sel);
    return (sel != 0) ? if2.value : if1.value;
  endfunction

  task automatic drive(input int sel, input logic st, input logic rs, input logic [31:0] s);
    if (sel != 0) begin
      if2.start = st; if2.reseed = rs; if2.seed = s;
    end else begin
      if1.start = st; if1.reseed = rs; if1.seed = s;
    end
  endtask

  task automatic run_word(input int sel, input logic [31:0] s, input bit rs, input string tag);
    exp_t e;
    logic [7:0] v;
    int lat;
    int seen_at;
    model_word(sel, s, rs, v, lat);
    e.val = v;
    e.lat = lat;
    sb.push_back(e);

    @(negedge clk);
    drive(sel, 1'b1, rs, s);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, s);

    seen_at = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy_early"}, 64'(get_busy(sel)), 64'd1);
      if (get_done(sel)) begin
        seen_at = k;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen_at != 0), 64'd1);
    if (seen_at != 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(seen_at), 64'(e.lat));
      check({tag, "_value"}, 64'(get_value(sel)), 64'(e.val));
      check({tag, "_busy_done"}, 64'(get_busy(sel)), 64'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(get_done(sel)), 64'd0);
      check({tag, "_value_hold"}, 64'(get_value(sel)), 64'(e.val));
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_value1", 64'(if1.value), 64'd0);
    check("rst_busy1",  64'(if1.busy),  64'd0);
    check("rst_done1",  64'(if1.done),  64'd0);
    check("rst_value2", 64'(if2.value), 64'd0);
    check("rst_busy2",  64'(if2.busy),  64'd0);
    check("rst_lfsr1",  64'(u_dut1.lfsr_state), 64'h1);

    run_word(0, 32'h1, 1'b0, "w1_seed1");
    check("w1_const_value", 64'(if1.value), 64'hDB);
    check("w1_lfsr_final",  64'(u_dut1.lfsr_state), 64'hDB36C002);

    run_word(0, 32'h1, 1'b0, "w2_continue");
    run_word(0, 32'h1, 1'b1, "w3_reseed");
    check("w3_const_value", 64'(if1.value), 64'hDB);
    run_word(0, 32'h0, 1'b0, "w4_zero_seed");
    check("w4_const_value", 64'(if1.value), 64'hDB);
    run_word(1, 32'h1, 1'b0, "w5_step2");
    check("w5_const_value", 64'(if2.value), 64'hDB);

    // Abort: same seed (no load), extra start during RUN, reset at RUN cycle 4.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0);
    seen = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (if1.done) seen = 1;
      if (k == 2) drive(0, 1'b1, 1'b0, 32'h0);
      if (k == 3) drive(0, 1'b0, 1'b0, 32'h0);
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        reset = 1'b0;
        model_reset();
      end
    end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_value",   64'(if1.value), 64'd0);
    check("abort_busy",    64'(if1.busy),  64'd0);

    run_word(0, 32'h0, 1'b0, "w6_reload");
    check("w6_const_value", 64'(if1.value), 64'hDB);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
